// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_pkg
//  Description : Shared definitions for the Huffman code generator and encoder.
//                Code word layout: [12:9] length L, [8:0] code right-aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
package huffman_pkg;
  localparam int SYM_NUM = 10;
  localparam int CODE_W  = 13;
  localparam int LEN_MSB = 12;
  localparam int LEN_LSB = 9;
  localparam int MAX_LEN = 9;

  // Marker for a symbol that has no usable code word
  localparam logic [CODE_W-1:0] CODE_INVALID = 13'h1FFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/huffman_encode_bitpack.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_bitpack
//  Description : MSB-first bit accumulator. Appends variable-length codes,
//                pops whole bytes and flags the final padded byte of a drain.
//  Ports       : append/app_len/app_code - add app_len bits of app_code
//                pop                     - remove the top byte
//                draining                - encoder is flushing
//                byte_out/valid/last     - top byte and its status
//                pad_bits                - zero pad bits in a last byte
//                fill                    - number of valid bits in acc
//  Revision    : 1.0 - initial release
// ============================================================================
module huffman_bitpack
  import huffman_pkg::*;
(
  input  logic       Clk_in,
  input  logic       n_Rst,
  input  logic       append,
  input  logic [3:0] app_len,
  input  logic [8:0] app_code,
  input  logic       pop,
  input  logic       draining,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_last,
  output logic [2:0] pad_bits,
  output logic [4:0] fill
);

  logic [15:0] r_acc;
  logic [4:0]  r_fill;
  logic [8:0]  w_code_bits;
  logic [15:0] w_ins;

  // Keep only the low L bits, then place them directly below the valid bits.
  // The caller only appends when fill<8 and L<=9, so the shift never goes negative.
  assign w_code_bits = app_code & (9'h1FF >> (4'd9 - app_len));
  assign w_ins       = {7'd0, w_code_bits} << (5'd16 - r_fill - {1'b0, app_len});

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      r_acc  <= 16'd0;
      r_fill <= 5'd0;
    end else if (pop) begin
      r_acc  <= r_acc << 8;
      r_fill <= (r_fill >= 5'd8) ? (r_fill - 5'd8) : 5'd0;
    end else if (append) begin
      r_acc  <= r_acc | w_ins;
      r_fill <= r_fill + {1'b0, app_len};
    end
  end

  assign byte_out   = r_acc[15:8];
  assign byte_valid = (r_fill >= 5'd8) || (draining && (r_fill != 5'd0));
  assign byte_last  = draining && (r_fill != 5'd0) && (r_fill <= 5'd8);
  // 8 - fill for fill in 1..8 equals -fill modulo 8
  assign pad_bits   = byte_last ? (3'd0 - r_fill[2:0]) : 3'd0;
  assign fill       = r_fill;

endmodule
`default_nettype wire

// File: rtl/huffman_encode.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_encode
//  Description : Captures ten per-digit code words and packs a stream of
//                4-bit digit symbols into MSB-first bytes, with flush/pad.
//  Ports       : Load_tbl, Code0..Code9  - table capture
//                Sym/Sym_valid/Sym_ready - symbol input handshake
//                Flush                   - drain and zero-pad request
//                Byte_out/valid/ready    - byte output handshake
//                Byte_last, Pad_bits     - final byte of a flush and its padding
//                Sym_err, Flush_done     - one-cycle event pulses
//                Tbl_ok                  - table loaded since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module huffman_encode
  import huffman_pkg::*;
(
  input  logic              Clk_in,
  input  logic              n_Rst,
  input  logic              Load_tbl,
  input  logic [CODE_W-1:0] Code0,
  input  logic [CODE_W-1:0] Code1,
  input  logic [CODE_W-1:0] Code2,
  input  logic [CODE_W-1:0] Code3,
  input  logic [CODE_W-1:0] Code4,
  input  logic [CODE_W-1:0] Code5,
  input  logic [CODE_W-1:0] Code6,
  input  logic [CODE_W-1:0] Code7,
  input  logic [CODE_W-1:0] Code8,
  input  logic [CODE_W-1:0] Code9,
  input  logic [3:0]        Sym,
  input  logic              Sym_valid,
  output logic              Sym_ready,
  input  logic              Flush,
  output logic [7:0]        Byte_out,
  output logic              Byte_valid,
  input  logic              Byte_ready,
  output logic              Byte_last,
  output logic [2:0]        Pad_bits,
  output logic              Sym_err,
  output logic              Flush_done,
  output logic              Tbl_ok
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_tbl [SYM_NUM];
  logic [CODE_W-1:0] w_code_in [SYM_NUM];
  logic              r_tbl_ok;
  logic              r_sym_err;
  logic              r_flush_done;

  logic [CODE_W-1:0] w_entry;
  logic [3:0]        w_len;
  logic              w_entry_ok;
  logic              w_sym_hs;
  logic              w_byte_hs;
  logic              w_sym_ready;
  logic              w_tbl_load;
  logic              w_drain_end;
  logic [4:0]        w_fill;
  logic              w_byte_valid;
  logic              w_byte_last;

  assign w_code_in = '{Code0, Code1, Code2, Code3, Code4,
                       Code5, Code6, Code7, Code8, Code9};

  // Table lookup; symbols 10..15 fall through to the invalid marker
  always_comb begin
    w_entry = CODE_INVALID;
    for (int i = 0; i < SYM_NUM; i++) begin
      if (Sym == i[3:0]) w_entry = r_tbl[i];
    end
  end

  assign w_len      = w_entry[LEN_MSB:LEN_LSB];
  assign w_entry_ok = (w_len != 4'd0) && (w_len <= 4'(MAX_LEN));
  assign w_sym_hs   = Sym_valid && w_sym_ready;
  assign w_byte_hs  = w_byte_valid && Byte_ready;

  // A flush ends when nothing is left, or when the last byte is taken
  assign w_drain_end = (r_state == FLUSH) &&
                       ((w_fill == 5'd0) || (w_byte_hs && w_byte_last));

  // State register
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (Load_tbl)    w_state_nxt = RUN;
      RUN:     if (Flush)       w_state_nxt = FLUSH;
      FLUSH:   if (w_drain_end) w_state_nxt = RUN;
      default:                  w_state_nxt = EMPTY;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_sym_ready = 1'b0;
    w_tbl_load  = 1'b0;
    case (r_state)
      EMPTY: w_tbl_load = Load_tbl;
      RUN: begin
        w_sym_ready = (w_fill < 5'd8);
        w_tbl_load  = Load_tbl;
      end
      default: ;
    endcase
  end

  // Table, status flag and event pulses. A symbol taken in the load cycle
  // already used the old entry, since the lookup reads r_tbl.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      for (int i = 0; i < SYM_NUM; i++) r_tbl[i] <= '0;
      r_tbl_ok     <= 1'b0;
      r_sym_err    <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      if (w_tbl_load) begin
        for (int i = 0; i < SYM_NUM; i++) r_tbl[i] <= w_code_in[i];
        r_tbl_ok <= 1'b1;
      end
      r_sym_err    <= w_sym_hs && !w_entry_ok;
      r_flush_done <= w_drain_end;
    end
  end

  huffman_bitpack u_bitpack (
    .Clk_in     (Clk_in),
    .n_Rst      (n_Rst),
    .append     (w_sym_hs && w_entry_ok),
    .app_len    (w_len),
    .app_code   (w_entry[LEN_LSB-1:0]),
    .pop        (w_byte_hs),
    .draining   (r_state == FLUSH),
    .byte_out   (Byte_out),
    .byte_valid (w_byte_valid),
    .byte_last  (w_byte_last),
    .pad_bits   (Pad_bits),
    .fill       (w_fill)
  );

  assign Sym_ready  = w_sym_ready;
  assign Byte_valid = w_byte_valid;
  assign Byte_last  = w_byte_last;
  assign Sym_err    = r_sym_err;
  assign Flush_done = r_flush_done;
  assign Tbl_ok     = r_tbl_ok;

endmodule
`default_nettype wire

// File: tb/tb_huffman_encode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huffman_encode
//  Description : Directed self-checking bench for huffman_encode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_encode;

  logic        Clk_in = 1'b0;
  logic        n_Rst = 1'b0;
  logic        Load_tbl = 1'b0;
  logic [12:0] code_v [10];
  logic [3:0]  Sym = 4'd0;
  logic        Sym_valid = 1'b0;
  logic        Sym_ready;
  logic        Flush = 1'b0;
  logic [7:0]  Byte_out;
  logic        Byte_valid;
  logic        Byte_ready = 1'b0;
  logic        Byte_last;
  logic [2:0]  Pad_bits;
  logic        Sym_err;
  logic        Flush_done;
  logic        Tbl_ok;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk_in = ~Clk_in;

  huffman_encode dut (
    .Clk_in     (Clk_in),
    .n_Rst      (n_Rst),
    .Load_tbl   (Load_tbl),
    .Code0      (code_v[0]),
    .Code1      (code_v[1]),
    .Code2      (code_v[2]),
    .Code3      (code_v[3]),
    .Code4      (code_v[4]),
    .Code5      (code_v[5]),
    .Code6      (code_v[6]),
    .Code7      (code_v[7]),
    .Code8      (code_v[8]),
    .Code9      (code_v[9]),
    .Sym        (Sym),
    .Sym_valid  (Sym_valid),
    .Sym_ready  (Sym_ready),
    .Flush      (Flush),
    .Byte_out   (Byte_out),
    .Byte_valid (Byte_valid),
    .Byte_ready (Byte_ready),
    .Byte_last  (Byte_last),
    .Pad_bits   (Pad_bits),
    .Sym_err    (Sym_err),
    .Flush_done (Flush_done),
    .Tbl_ok     (Tbl_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic load_table();
    Load_tbl = 1'b1;
    tick();
    Load_tbl = 1'b0;
  endtask

  task automatic send_sym(input logic [3:0] s);
    logic done;
    done = 1'b0;
    Sym = s;
    Sym_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (Sym_ready) done = 1'b1;
      tick();
    end
    Sym_valid = 1'b0;
    check("sym_accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic get_byte(input string tag, input logic [7:0] exp_b,
                          input logic exp_last, input logic [2:0] exp_pad);
    logic seen;
    seen = Byte_valid;
    Byte_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = Byte_valid;
    end
    check({tag, "_valid"}, {31'd0, seen}, 32'd1);
    check({tag, "_byte"},  {24'd0, Byte_out}, {24'd0, exp_b});
    check({tag, "_last"},  {31'd0, Byte_last}, {31'd0, exp_last});
    check({tag, "_pad"},   {29'd0, Pad_bits}, {29'd0, exp_pad});
    tick();
    Byte_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) code_v[i] = 13'd0;
    code_v[0] = 13'h1FFF;
    code_v[1] = {4'd2, 9'b10};
    code_v[2] = {4'd3, 9'b101};
    code_v[9] = {4'd9, 9'h1FF};

    // Reset state
    #12;
    check("rst_sym_ready",  {31'd0, Sym_ready}, 32'd0);
    check("rst_byte_valid", {31'd0, Byte_valid}, 32'd0);
    check("rst_byte_out",   {24'd0, Byte_out}, 32'd0);
    check("rst_tbl_ok",     {31'd0, Tbl_ok}, 32'd0);
    n_Rst = 1'b1;
    tick();
    check("empty_sym_ready", {31'd0, Sym_ready}, 32'd0);
    load_table();
    check("tbl_ok", {31'd0, Tbl_ok}, 32'd1);
    check("run_sym_ready", {31'd0, Sym_ready}, 32'd1);

    // 1,1,1,1 -> 0xAA, held while Byte_ready is low
    for (int i = 0; i < 4; i++) send_sym(4'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, Byte_valid}, 32'd1);
      check("hold_byte", {24'd0, Byte_out}, 32'h0000_00AA);
      check("hold_sym_ready", {31'd0, Sym_ready}, 32'd0);
      tick();
    end
    Byte_ready = 1'b1;
    tick();
    Byte_ready = 1'b0;
    check("aa_drained_valid", {31'd0, Byte_valid}, 32'd0);
    check("aa_sym_ready", {31'd0, Sym_ready}, 32'd1);
    tick();
    check("aa_one_byte", {31'd0, Byte_valid}, 32'd0);

    // 9 then flush -> 0xFF, 0x80 last with 7 pad bits
    send_sym(4'd9);
    check("nine_last_in_run", {31'd0, Byte_last}, 32'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_sym_ready", {31'd0, Sym_ready}, 32'd0);
    get_byte("f9_b0", 8'hFF, 1'b0, 3'd0);
    get_byte("f9_b1", 8'h80, 1'b1, 3'd7);
    check("f9_done", {31'd0, Flush_done}, 32'd1);
    check("f9_done_valid", {31'd0, Byte_valid}, 32'd0);
    tick();
    check("f9_done_pulse", {31'd0, Flush_done}, 32'd0);

    // Invalid entries
    send_sym(4'd0);
    check("err0", {31'd0, Sym_err}, 32'd1);
    tick();
    check("err0_pulse", {31'd0, Sym_err}, 32'd0);
    send_sym(4'd12);
    check("err12", {31'd0, Sym_err}, 32'd1);
    check("err_no_byte", {31'd0, Byte_valid}, 32'd0);

    // Flush with fill=0 (also proves the invalid symbols added no bits)
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("f0_no_byte", {31'd0, Byte_valid}, 32'd0);
    check("f0_not_yet", {31'd0, Flush_done}, 32'd0);
    tick();
    check("f0_done", {31'd0, Flush_done}, 32'd1);
    check("f0_no_byte2", {31'd0, Byte_valid}, 32'd0);

    // Symbol and flush in the same cycle: 101 padded -> 0xA0, pad 5
    check("sf_ready", {31'd0, Sym_ready}, 32'd1);
    Sym = 4'd2;
    Sym_valid = 1'b1;
    Flush = 1'b1;
    tick();
    Sym_valid = 1'b0;
    Flush = 1'b0;
    get_byte("sf", 8'hA0, 1'b1, 3'd5);
    check("sf_done", {31'd0, Flush_done}, 32'd1);

    // Load_tbl during FLUSH is ignored
    send_sym(4'd9);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    code_v[1] = {4'd1, 9'b1};
    load_table();
    get_byte("lf_b0", 8'hFF, 1'b0, 3'd0);
    get_byte("lf_b1", 8'h80, 1'b1, 3'd7);
    for (int i = 0; i < 4; i++) send_sym(4'd1);
    check("lf_old_code_valid", {31'd0, Byte_valid}, 32'd1);
    check("lf_old_code_byte", {24'd0, Byte_out}, 32'h0000_00AA);
    get_byte("lf_aa", 8'hAA, 1'b0, 3'd0);

    // Asynchronous reset in the middle of a flush
    send_sym(4'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("mid_last", {31'd0, Byte_last}, 32'd1);
    #2;
    n_Rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, Byte_valid}, 32'd0);
    check("arst_last", {31'd0, Byte_last}, 32'd0);
    check("arst_pad", {29'd0, Pad_bits}, 32'd0);
    check("arst_byte", {24'd0, Byte_out}, 32'd0);
    check("arst_tbl_ok", {31'd0, Tbl_ok}, 32'd0);
    check("arst_sym_ready", {31'd0, Sym_ready}, 32'd0);
    tick();
    n_Rst = 1'b1;
    Sym_valid = 1'b1;
    Sym = 4'd1;
    tick();
    tick();
    check("post_rst_sym_ready", {31'd0, Sym_ready}, 32'd0);
    check("post_rst_no_byte", {31'd0, Byte_valid}, 32'd0);
    Sym_valid = 1'b0;
    load_table();
    check("reload_sym_ready", {31'd0, Sym_ready}, 32'd1);

    // The reload picked up the new one-bit code for symbol 1
    send_sym(4'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    get_byte("new1", 8'h80, 1'b1, 3'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
